// File: rtl/button_pkg.sv
// Shared defaults and width helper for the button conditioner and its channels.
package button_pkg;

    localparam int DEF_PORT_WIDTH   = 4;
    localparam int DEF_DEBNC_CLOCKS = 65536;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_LONG_CLOCKS  = 1 << 24;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/button_chan.sv
// One conditioned input: synchroniser, debounce counter, edge pulses and long-press detection.
module button_chan
    import button_pkg::*;
#(
    parameter int DEBNC_CLOCKS = DEF_DEBNC_CLOCKS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int LONG_CLOCKS  = DEF_LONG_CLOCKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam int DW = clog2(DEBNC_CLOCKS);
    localparam int HW = clog2(LONG_CLOCKS) + 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBNC_CLOCKS - 1);
    localparam logic [HW-1:0] HOLD_SAT = HW'(LONG_CLOCKS);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CLOCKS - 2);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [DW-1:0]          deb_cnt_reg;
    logic [HW-1:0]          hold_cnt_reg;
    logic                   level_reg;
    logic                   rise_reg;
    logic                   fall_reg;
    logic                   long_reg;
    logic                   sync;
    logic                   accept;

    assign sync   = sync_reg[SYNC_STAGES-1];
    assign accept = (sync != level_reg) && (deb_cnt_reg == DEB_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
        end
    end

    // Any agreeing cycle restarts the count, so glitches leave no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt_reg <= '0;
            level_reg   <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            rise_reg <= accept && !level_reg;
            fall_reg <= accept && level_reg;
            if (sync == level_reg) begin
                deb_cnt_reg <= '0;
            end else if (accept) begin
                deb_cnt_reg <= '0;
                level_reg   <= ~level_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    // Saturating hold count passes LONG_CLOCKS-1 only once per press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
            long_reg     <= 1'b0;
        end else begin
            long_reg <= level_reg && (hold_cnt_reg == HOLD_PRE);
            if (!level_reg) begin
                hold_cnt_reg <= '0;
            end else if (hold_cnt_reg != HOLD_SAT) begin
                hold_cnt_reg <= hold_cnt_reg + 1'b1;
            end
        end
    end

    assign level      = level_reg;
    assign rise       = rise_reg;
    assign fall       = fall_reg;
    assign long_press = long_reg;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: one independent button_chan per input bit.
module button_conditioner
    import button_pkg::*;
#(
    parameter int PORT_WIDTH   = DEF_PORT_WIDTH,
    parameter int DEBNC_CLOCKS = DEF_DEBNC_CLOCKS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int LONG_CLOCKS  = DEF_LONG_CLOCKS
) (
    input  logic                  CLK_I,
    input  logic                  RSTN_I,
    input  logic [PORT_WIDTH-1:0] SIGNAL_I,
    output logic [PORT_WIDTH-1:0] SIGNAL_O,
    output logic [PORT_WIDTH-1:0] RISE_O,
    output logic [PORT_WIDTH-1:0] FALL_O,
    output logic [PORT_WIDTH-1:0] LONG_O
);

    generate
        for (genvar gi = 0; gi < PORT_WIDTH; gi++) begin : g_chan
            button_chan #(
                .DEBNC_CLOCKS(DEBNC_CLOCKS),
                .SYNC_STAGES (SYNC_STAGES),
                .LONG_CLOCKS (LONG_CLOCKS)
            ) u_chan (
                .clk       (CLK_I),
                .rst_n     (RSTN_I),
                .raw       (SIGNAL_I[gi]),
                .level     (SIGNAL_O[gi]),
                .rise      (RISE_O[gi]),
                .fall      (FALL_O[gi]),
                .long_press(LONG_O[gi])
            );
        end
    endgenerate

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter PORT_WIDTH, default 4: number of independent input channels.
REQ-002 The block SHALL have parameter DEBNC_CLOCKS, default 65536: consecutive disagreeing cycles required to accept a new level (legal range 2 or more).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth (legal range 2 or more).
REQ-004 The block SHALL have parameter LONG_CLOCKS, default 2^24: cycles of continuous debounced-high before a long-press event (legal range 2 or more).
REQ-005 The block SHALL have port CLK_I, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-006 The block SHALL have port RSTN_I, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port SIGNAL_I, input, PORT_WIDTH bits: raw asynchronous button/switch levels.
REQ-008 The block SHALL have port SIGNAL_O, output, PORT_WIDTH bits: debounced level per channel.
REQ-009 The block SHALL have port RISE_O, output, PORT_WIDTH bits: one-cycle pulse on each debounced 0->1 transition.
REQ-010 The block SHALL have port FALL_O, output, PORT_WIDTH bits: one-cycle pulse on each debounced 1->0 transition.
REQ-011 The block SHALL have port LONG_O, output, PORT_WIDTH bits: one-cycle pulse when a channel has been debounced-high for LONG_CLOCKS cycles.

Function
REQ-012 Each channel SHALL pass SIGNAL_I through SYNC_STAGES flops; only the last stage (sync) SHALL feed the debounce logic.
REQ-013 Per channel, the debounce counter SHALL be clog2(DEBNC_CLOCKS) bits wide; no fixed 32-bit counters.
REQ-014 While sync equals SIGNAL_O, the debounce counter SHALL clear to 0 on every cycle.
REQ-015 While sync differs from SIGNAL_O and the counter is below DEBNC_CLOCKS-1, the counter SHALL increment by 1.
REQ-016 While sync differs from SIGNAL_O and the counter equals DEBNC_CLOCKS-1, the next edge SHALL invert SIGNAL_O and clear the counter.
REQ-017 After a clean step on SIGNAL_I, SIGNAL_O SHALL change exactly SYNC_STAGES+DEBNC_CLOCKS rising edges later.
REQ-018 A glitch shorter than DEBNC_CLOCKS synchronised cycles SHALL NOT change SIGNAL_O, and SHALL leave the counter at 0 once it ends.
REQ-019 RISE_O and FALL_O SHALL be registered and asserted in the same cycle SIGNAL_O shows the new level, for exactly one cycle.
REQ-020 The hold counter SHALL be clog2(LONG_CLOCKS)+1 bits wide, clear whenever SIGNAL_O is 0, and increment while SIGNAL_O is 1.
REQ-021 The hold counter SHALL saturate, not wrap, on reaching LONG_CLOCKS.
REQ-022 LONG_O SHALL pulse for one cycle when the hold counter reaches LONG_CLOCKS-1, and SHALL pulse at most once per press.
REQ-023 A release before LONG_CLOCKS SHALL produce no LONG_O pulse.
REQ-024 Channels SHALL be fully independent, so simultaneous events on several channels SHALL all be reported in the same cycle.

Reset
REQ-025 RSTN_I low SHALL immediately, without waiting for a clock edge, set all synchroniser flops, counters, SIGNAL_O, RISE_O, FALL_O and LONG_O to 0.
REQ-026 Reset asserted mid-count SHALL discard all partial debounce and hold progress.
REQ-027 After reset release with SIGNAL_I held high, no pulse SHALL appear on FALL_O.
REQ-028 After reset release with SIGNAL_I held high, RISE_O SHALL pulse after the normal REQ-017 latency.
REQ-029 No initial blocks SHALL be used for state initialisation.

Structure
REQ-030 Default parameter values and the clog2 helper SHALL live in shared package button_pkg.
REQ-031 The per-channel synchroniser, debounce counter, edge detection and hold counter SHALL be in sub-module button_chan, instantiated PORT_WIDTH times by a generate loop.

Verification
REQ-032 With PORT_WIDTH=4, DEBNC_CLOCKS=4, SYNC_STAGES=2, LONG_CLOCKS=8, a bench SHALL cover the directed scenarios REQ-033 to REQ-037.
REQ-033 Step ch0 0->1 at edge N -> SIGNAL_O[0]=1 and RISE_O[0]=1 at edge N+6, RISE_O[0]=0 at N+7; no other channel changes.
REQ-034 Ch1 high for 3 cycles then low -> SIGNAL_O[1] stays 0, RISE_O[1] never pulses.
REQ-035 Ch2 held high 20 cycles after acceptance -> exactly one LONG_O[2] pulse, 7 edges after RISE_O[2]; release -> FALL_O[2] pulse 6 edges after the input falls, no further LONG_O.
REQ-036 Ch0 and ch3 step high on the same edge -> RISE_O=4'b1001 in a single cycle.
REQ-037 RSTN_I pulsed low asynchronously (between edges) while the ch0 counter=2 -> all outputs 0 immediately; after release with the input still high, RISE_O[0] pulses 6 edges later and FALL_O[0] never pulses.
